// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared link constants, packet type and transmitter state
//                encoding. Both ends of the link import this package so the
//                bit period is computed identically on each side.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int CLK_HZ       = 100_000_000;
    localparam int BAUD_RATE    = 9600;
    localparam int SAMP_PER_BIT = 16;
    localparam int PKT_LNGTH    = 162;
    localparam int WAIT_TIME    = 20_000_000;

    // Truncate to whole oversample ticks first so the transmitter bit period
    // equals the receiver's sampled bit period exactly.
    localparam int CLK_PER_BIT  = (CLK_HZ / (SAMP_PER_BIT * BAUD_RATE)) * SAMP_PER_BIT;

    // Idle-high interval: receiver arm time (ns -> 10 ns clocks) plus one bit.
    localparam int GUARD_CLKS   = WAIT_TIME / 10 + CLK_PER_BIT;

    localparam int CNT_W        = 22;
    localparam int BIT_IDX_W    = 8;

    typedef logic [PKT_LNGTH-1:0] pkt_t;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_GUARD = 5'b00010,
        ST_START = 5'b00100,
        ST_DATA  = 5'b01000,
        ST_STOP  = 5'b10000
    } state_e;

endpackage
`default_nettype wire

// File: rtl/uat_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uat_bit_timer
//  Description : Loadable down-counter. tc_o is high while the count is zero;
//                the count holds at zero until reloaded.
//  Revision    : 1.0 - initial release
// ============================================================================
module uat_bit_timer #(
    parameter int CNT_W = 22
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    // Reload on request, otherwise count down and stick at zero.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/uat_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : uat_fsm
//  Description : Single-wire packet transmitter. Sends an idle-high guard,
//                one low start bit, PKT_LNGTH data bits LSB first and one
//                high stop bit. All outputs come straight from flops.
//  Revision    : 1.0 - initial release
// ============================================================================
module uat_fsm #(
    parameter int GUARD_CLKS  = uart_pkg::GUARD_CLKS,
    parameter int CLK_PER_BIT = uart_pkg::CLK_PER_BIT
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [uart_pkg::PKT_LNGTH-1:0] data_in,
    input  logic                          send,
    output logic                          sig_out,
    output logic                          busy,
    output logic                          done
);

    import uart_pkg::*;

    localparam logic [CNT_W-1:0]     c_GUARD_LOAD = CNT_W'(GUARD_CLKS - 1);
    localparam logic [CNT_W-1:0]     c_BIT_LOAD   = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] c_LAST_BIT   = BIT_IDX_W'(PKT_LNGTH - 1);

    state_e               state_q, state_d;
    pkt_t                 shreg_q, shreg_d;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic                 sig_q, sig_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_val;
    logic                 tmr_tc;

    uat_bit_timer #(
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    // State, shift register and registered line/status outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            sig_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            sig_q     <= sig_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; the line value is computed one cycle ahead so the
    // flop presents it exactly on the phase-change edge.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        sig_d     = sig_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = c_BIT_LOAD;

        case (state_q)
            ST_IDLE: begin
                sig_d  = 1'b1;
                busy_d = 1'b0;
                if (send) begin
                    shreg_d  = data_in;
                    busy_d   = 1'b1;
                    state_d  = ST_GUARD;
                    tmr_load = 1'b1;
                    tmr_val  = c_GUARD_LOAD;
                end
            end
            ST_GUARD: begin
                sig_d = 1'b1;
                if (tmr_tc) begin
                    state_d  = ST_START;
                    sig_d    = 1'b0;
                    tmr_load = 1'b1;
                end
            end
            ST_START: begin
                if (tmr_tc) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    sig_d     = shreg_q[0];
                    tmr_load  = 1'b1;
                end
            end
            ST_DATA: begin
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    if (bit_idx_q == c_LAST_BIT) begin
                        state_d = ST_STOP;
                        sig_d   = 1'b1;
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                        sig_d     = shreg_q[1];
                    end
                end
            end
            ST_STOP: begin
                sig_d = 1'b1;
                if (tmr_tc) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                // Corrupted state register: park the line high and go idle.
                state_d   = ST_IDLE;
                sig_d     = 1'b1;
                busy_d    = 1'b0;
                bit_idx_d = '0;
            end
        endcase
    end

    assign sig_out = sig_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: doc/uat_fsm.md
Name: uat_fsm

Overview:
- Packet transmitter that serializes one 162-bit packet onto a single-wire async line.
- Sits directly upstream of the 162-bit packet receiver, on the other end of the link.
- Line format it guarantees:
  - idle-high guard interval long enough to arm the receiver;
  - one low start bit;
  - 162 data bits, LSB first;
  - one high stop bit.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- BAUD_RATE, 9600, line bit rate.
- SAMP_PER_BIT, 16, receiver oversample factor; used only to derive CLK_PER_BIT.
- CLK_PER_BIT, (CLK_HZ/(SAMP_PER_BIT*BAUD_RATE))*SAMP_PER_BIT = 10416, clocks per line bit. Computed this way so it matches the receiver's truncated bit period exactly.
- PKT_LNGTH, 162, data bits per packet.
- WAIT_TIME, 20_000_000, receiver idle-arm time in ns.
- GUARD_CLKS, WAIT_TIME/10 + CLK_PER_BIT = 2_010_416, clocks of forced idle-high before the start bit.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- data_in  input  162  packet to send; sampled only on an accepted send.
- send  input  1  single-cycle request; accepted only when busy==0.
- sig_out  output  1  serial line, registered; idle high.
- busy  output  1  high from accepted send until packet complete.
- done  output  1  one-cycle pulse at packet completion.

Behaviour:
- Reset (rst_in low, asynchronous):
  - state=IDLE, sig_out=1, busy=0, done=0;
  - shift register, cycle counter and bit counter cleared.
- Reset mid-packet: the line returns high immediately and the packet is abandoned. No done pulse is issued.
- States (one-hot): IDLE, GUARD, START, DATA, STOP.
- IDLE:
  - sig_out=1.
  - send=1 at edge E0: latch data_in, busy=1 at E0, enter GUARD, cnt=0.
- GUARD:
  - sig_out=1 for exactly GUARD_CLKS cycles.
  - At the final count: enter START.
  - sig_out falls at edge E0+GUARD_CLKS.
- START:
  - sig_out=0 for CLK_PER_BIT cycles.
  - Then enter DATA with bit_idx=0.
- DATA:
  - sig_out = shreg[0]. Bit i is driven from edge E0+GUARD_CLKS+(i+1)*CLK_PER_BIT.
  - On each bit-period wrap: shift right, bit_idx+1.
  - After bit_idx==PKT_LNGTH-1 completes: enter STOP.
- STOP:
  - sig_out=1 for CLK_PER_BIT cycles, starting at edge E0+GUARD_CLKS+163*CLK_PER_BIT.
  - Then, at edge E0+GUARD_CLKS+164*CLK_PER_BIT: done=1 for one cycle, busy=0, return to IDLE.
- Total packet duration: GUARD_CLKS + 164*CLK_PER_BIT clocks.
- send while busy: ignored. data_in changes while busy: ignored.
- send asserted in the cycle done pulses: ignored, because busy is still high at that edge. It is accepted the next cycle.
- Counter widths:
  - cnt is 22 bits (max GUARD_CLKS-1 < 2^22).
  - bit_idx is 8 bits.
  - All compares are equality against terminal value-1; counters never wrap uncontrolled.
- sig_out is driven only from a flop, so the line never glitches.
- Illegal or non-one-hot state: recover to IDLE with sig_out=1.

Decomposition:
- Package uart_pkg holds:
  - CLK_HZ, BAUD_RATE, SAMP_PER_BIT, PKT_LNGTH, WAIT_TIME;
  - the derived CLK_PER_BIT;
  - the typedef pkt_t = logic [161:0];
  - the state encoding constants.
- Both link ends import the package so the bit period cannot diverge.
- One natural sub-module: uat_bit_timer.
  - Loadable down-counter with a terminal-count pulse.
  - Serves both GUARD (load GUARD_CLKS-1) and bit periods (load CLK_PER_BIT-1).

Test Plan:
- Simulation uses GUARD_CLKS=40 and CLK_PER_BIT=16 for speed.
- Reset: hold rst_in low mid-clock -> sig_out=1, busy=0, done=0 immediately, before the next edge.
- Single packet:
  - Stimulus: data_in=162'h1 then 162'h2_AAAA..._5555 (alternating), send pulse.
  - Required: 40 high cycles; 16-cycle low start; bits LSB first, each 16 cycles; 16-cycle stop.
  - Required: done at exactly cycle 40+164*16=2664 after send; busy low the same edge.
- Send while busy: pulse send at cycle 100 with different data_in -> no effect; line matches the original packet bit-for-bit; exactly one done.
- Back-to-back: send held high continuously -> second packet begins exactly one cycle after done, with a full 40-cycle guard.
- Reset mid-DATA:
  - Stimulus: rst_in low at bit 50.
  - Required: sig_out=1 at once; no done pulse.
  - After release, a new send produces a correct full packet.
- Loopback: default parameters, transmitter line wired into the packet receiver, random 162-bit payload -> receiver data_out equals the payload and its ready reasserts.
